wb_sdram_master: RTL and testbench

- Wishbone B3 initiator that drives the SDRAM controller's slave port (stb/cyc/addr/we/dat/sel/cti in, ack/dat out).
- Accepts one command at a time from a simple valid/ready request port and issues either a classic single cycle or an incrementing burst of up to 8 beats.
- Returns read data beat by beat and signals completion.
- Sits between the test/DSP data path and the SDRAM controller, producing the traffic the SDRAM interface checker observes.

---
 rtl/wb_sdram_master_if.sv | 30 +++
 rtl/wb_sdram_master.sv | 157 +++++++++++++++
 tb/tb_wb_sdram_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sdram_master_if.sv
// Wishbone B3 bus bundle between the SDRAM traffic master and the SDRAM
// controller slave port.
//   master modport : drives cyc/stb/we/addr/dat/sel/cti, samples dat_i/ack
//   slave  modport : the mirror image, for the controller or a bench model
interface wb_sdram_master_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_sdram_master.sv
// Wishbone B3 initiator for the SDRAM controller slave port.
// Takes one command at a time from a valid/ready request port and issues a
// classic single cycle (len=0) or an incrementing burst of len+1 beats.
//   clk_i, rst_n_i        : clock, async active-low reset
//   req_*                 : command port (addr, we, sel, len = beats-1)
//   wdata_i / wbeat_o     : write beat data / "beat taken, show next" pulse
//   rdata_o / rvalid_o    : read beat data / valid pulse
//   done_o, err_o, busy_o : completion pulse, abort pulse, in-flight flag
//   wb                    : Wishbone master bundle (wb_sdram_master_if)
// Optional: define WB_MASTER_TIMEOUT_EN to abort a command after
// TIMEOUT_CYCLES consecutive BUS cycles without ack.
module wb_sdram_master #(
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 32,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_W         = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [SEL_W-1:0]  req_sel_i,
  input  logic [2:0]        req_len_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              wbeat_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  wb_sdram_master_if.master wb
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  // FIN / ABRT are the one-cycle done / err pulse states; they also give the
  // mandatory idle gap between commands.
  typedef enum logic [1:0] {IDLE, BUS, FIN, ABRT} state_t;
  state_t state, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [SEL_W-1:0]  sel_q;
  logic [2:0]        len_q;
  logic [BEAT_W-1:0] beat_q;
  logic              wbeat_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic ack_bus, last_beat, tmo_hit;

  assign ack_bus   = (state == BUS) && wb.wb_ack_i;
  assign last_beat = (3'(beat_q) == len_q);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Held at 0 outside BUS, so it is already cleared on BUS entry.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i)                     tmo_q <= '0;
    else if (state != BUS || ack_bus) tmo_q <= '0;
    else                              tmo_q <= tmo_q + 1'b1;

  // The edge that would take the count to TIMEOUT_CYCLES is the abort edge.
  assign tmo_hit = (state == BUS) && !wb.wb_ack_i &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else          state <= nxt;

  // next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req_valid_i)           nxt = BUS;
      BUS:  if (ack_bus && last_beat)  nxt = FIN;
            else if (tmo_hit)          nxt = ABRT;
      FIN:                             nxt = IDLE;
      ABRT:                            nxt = IDLE;
      default:                         nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    wb.wb_cyc_o  = 1'b0;
    wb.wb_stb_o  = 1'b0;
    wb.wb_we_o   = 1'b0;
    wb.wb_addr_o = '0;
    wb.wb_dat_o  = '0;
    wb.wb_sel_o  = '0;
    wb.wb_cti_o  = 3'b000;
    req_ready_o  = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    busy_o       = 1'b1;
    case (state)
      IDLE: begin
        busy_o      = 1'b0;
        // held low while reset is asserted even though the state is IDLE
        req_ready_o = rst_n_i;
      end
      BUS: begin
        wb.wb_cyc_o  = 1'b1;
        wb.wb_stb_o  = 1'b1;
        wb.wb_we_o   = we_q;
        wb.wb_addr_o = addr_q;
        wb.wb_dat_o  = we_q ? wdata_i : '0;
        wb.wb_sel_o  = sel_q;
        if (len_q != 3'd0) wb.wb_cti_o = last_beat ? 3'b111 : 3'b010;
      end
      FIN:  done_o = 1'b1;
      ABRT: err_o  = 1'b1;
      default: ;
    endcase
  end

  // command registers and beat bookkeeping
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      wbeat_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wbeat_q  <= ack_bus && we_q;
      rvalid_q <= ack_bus && !we_q;
      if (ack_bus && !we_q) rdata_q <= wb.wb_dat_i;
      if (state == IDLE && req_valid_i) begin
        addr_q <= req_addr_i;
        we_q   <= req_we_i;
        sel_q  <= req_sel_i;
        len_q  <= req_len_i;
        beat_q <= '0;
      end else if (ack_bus && !last_beat) begin
        addr_q <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
        beat_q <= beat_q + 1'b1;
      end
    end

  assign wbeat_o  = wbeat_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_wb_sdram_master.sv
module tb_wb_sdram_master;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [SEL_W-1:0]  req_sel;
  logic [2:0]        req_len;
  logic [DATA_W-1:0] wdata, rdata;
  logic              wbeat, rvalid, done, err, busy;

  int n_chk = 0;
  int n_err = 0;

  wb_sdram_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

  wb_sdram_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_sel_i(req_sel), .req_len_i(req_len),
    .wdata_i(wdata), .wbeat_o(wbeat), .rdata_o(rdata), .rvalid_o(rvalid),
    .done_o(done), .err_o(err), .busy_o(busy), .wb(wb.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, land 1ns after the rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic we,
                       input logic [2:0] len, input logic [DATA_W-1:0] d);
    req_valid = 1'b1; req_addr = a; req_we = we; req_sel = 4'hF;
    req_len = len; wdata = d;
    chk("ready_before_accept", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("cyc_after_accept", wb.wb_cyc_o, 1'b1);
    chk("busy_after_accept", busy, 1'b1);
    chk("ready_while_busy", req_ready, 1'b0);
  endtask

  logic [DATA_W-1:0] rd_tab [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    int n, errs, dones;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_sel = '0; req_len = '0; wdata = '0;
    wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0;

    // ---- reset with a pending read command
    req_valid = 1'b1; req_addr = 26'h0000040; req_we = 1'b0; req_sel = 4'hF;
    repeat (5) tick();
    chk("rst_cyc", wb.wb_cyc_o, 1'b0);
    chk("rst_stb", wb.wb_stb_o, 1'b0);
    chk("rst_addr", wb.wb_addr_o, 0);
    chk("rst_sel", wb.wb_sel_o, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    rst_n = 1'b1; #1;
    chk("rel_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("rel_accept_cyc", wb.wb_cyc_o, 1'b1);
    chk("rel_accept_addr", wb.wb_addr_o, 26'h40);
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h5A5A0001;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("rel_rvalid", rvalid, 1'b1);
    chk("rel_rdata", rdata, 32'h5A5A0001);
    chk("rel_done", done, 1'b1);
    tick();

    // ---- single write, 3 wait states
    issue(26'h0000100, 1'b1, 3'd0, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      chk("sw_cyc", wb.wb_cyc_o, 1'b1);
      chk("sw_stb", wb.wb_stb_o, 1'b1);
      chk("sw_cti", wb.wb_cti_o, 3'b000);
      chk("sw_dat", wb.wb_dat_o, 32'hDEADBEEF);
      chk("sw_we", wb.wb_we_o, 1'b1);
      chk("sw_addr", wb.wb_addr_o, 26'h100);
      chk("sw_wbeat_early", wbeat, 1'b0);
      if (i == 3) wb.wb_ack_i = 1'b1;
      tick();
    end
    wb.wb_ack_i = 1'b0;
    chk("sw_cyc_fall", wb.wb_cyc_o, 1'b0);
    chk("sw_stb_fall", wb.wb_stb_o, 1'b0);
    chk("sw_dat_idle", wb.wb_dat_o, 0);
    chk("sw_wbeat", wbeat, 1'b1);
    chk("sw_done", done, 1'b1);
    chk("sw_busy_done", busy, 1'b1);
    chk("sw_err", err, 1'b0);
    tick();
    chk("sw_done_once", done, 1'b0);
    chk("sw_wbeat_once", wbeat, 1'b0);
    chk("sw_idle_busy", busy, 1'b0);

    // ---- ack outside BUS is ignored
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hBAD;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("idle_ack_rvalid", rvalid, 1'b0);
    chk("idle_ack_done", done, 1'b0);

    // ---- 4-beat read burst, ack every cycle
    issue(26'h0000200, 1'b0, 3'd3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rb_addr", wb.wb_addr_o, 26'h200 + i);
      chk("rb_cti", wb.wb_cti_o, (i == 3) ? 3'b111 : 3'b010);
      chk("rb_we", wb.wb_we_o, 1'b0);
      chk("rb_dat_o", wb.wb_dat_o, 0);
      wb.wb_ack_i = 1'b1; wb.wb_dat_i = rd_tab[i];
      tick();
      chk("rb_rvalid", rvalid, 1'b1);
      chk("rb_rdata", rdata, rd_tab[i]);
      chk("rb_done", done, (i == 3) ? 1'b1 : 1'b0);
    end
    wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'h99;
    chk("rb_cyc_fall", wb.wb_cyc_o, 1'b0);
    chk("rb_cti_idle", wb.wb_cti_o, 3'b000);
    tick();
    chk("rb_rvalid_end", rvalid, 1'b0);
    chk("rb_rdata_hold", rdata, 32'h44);

    // ---- address wrap, 2-beat write
    issue(26'h3FFFFFF, 1'b1, 3'd1, 32'hA0A0A0A0);
    chk("wr_addr0", wb.wb_addr_o, 26'h3FFFFFF);
    chk("wr_cti0", wb.wb_cti_o, 3'b010);
    wb.wb_ack_i = 1'b1;
    tick();
    chk("wr_wbeat0", wbeat, 1'b1);
    wdata = 32'hB1B1B1B1; #1;
    chk("wr_addr1", wb.wb_addr_o, 26'h0000000);
    chk("wr_cti1", wb.wb_cti_o, 3'b111);
    chk("wr_dat1", wb.wb_dat_o, 32'hB1B1B1B1);
    tick();
    wb.wb_ack_i = 1'b0;
    chk("wr_done", done, 1'b1);
    chk("wr_cyc_fall", wb.wb_cyc_o, 1'b0);
    tick();

    // ---- reset mid 8-beat write
    issue(26'h0000300, 1'b1, 3'd7, 32'h12345678);
    wb.wb_ack_i = 1'b1;
    repeat (3) tick();
    wb.wb_ack_i = 1'b0;
    chk("mr_addr_before", wb.wb_addr_o, 26'h303);
    chk("mr_cyc_before", wb.wb_cyc_o, 1'b1);
    #2 rst_n = 1'b0; #1;
    chk("mr_cyc_async", wb.wb_cyc_o, 1'b0);
    chk("mr_stb_async", wb.wb_stb_o, 1'b0);
    chk("mr_busy_async", busy, 1'b0);
    dones = 0; errs = 0;
    repeat (3) begin
      tick();
      if (done) dones++;
      if (err) errs++;
    end
    chk("mr_no_done", dones, 0);
    chk("mr_no_err", errs, 0);
    rst_n = 1'b1;
    tick();
    issue(26'h0000400, 1'b0, 3'd0, 32'h0);
    chk("mr_new_cti", wb.wb_cti_o, 3'b000);
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hCAFEF00D;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("mr_new_rdata", rdata, 32'hCAFEF00D);
    chk("mr_new_done", done, 1'b1);
    tick();

    // ---- no ack: timeout or wait forever
    issue(26'h0000500, 1'b0, 3'd0, 32'h0);
    n = 0; errs = 0; dones = 0;
    while (wb.wb_cyc_o && n < 1000) begin
      n++;
      tick();
      if (err) errs++;
      if (done) dones++;
    end
`ifdef WB_MASTER_TIMEOUT_EN
    chk("to_cycles", n, 16);
    chk("to_err_once", errs, 1);
    chk("to_no_done", dones, 0);
    chk("to_err_now", err, 1'b1);
    tick();
    chk("to_err_clear", err, 1'b0);
    chk("to_idle_ready", req_ready, 1'b1);
`else
    chk("nto_still_cyc", wb.wb_cyc_o, 1'b1);
    chk("nto_waited", n, 1000);
    chk("nto_no_err", errs, 0);
    chk("nto_no_done", dones, 0);
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h600D;
    tick();
    wb.wb_ack_i = 1'b0;
    chk("nto_late_done", done, 1'b1);
    chk("nto_late_rdata", rdata, 32'h600D);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
